// File: rtl/program_loader_pkg.sv
// Shared constants and types for the program loader: command/header bytes,
// FSM state encoding, memory-target selector and default widths.
package program_loader_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [7:0] HDR_INSTR = 8'hA5;
  localparam logic [7:0] HDR_DATA  = 8'h5A;
  localparam logic [7:0] CMD_RUN   = 8'hC3;
  localparam logic [7:0] CMD_HALT  = 8'h3C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CSUM,
    S_RUN
  } state_t;

  typedef enum logic {
    TGT_INSTR,
    TGT_DATA
  } target_t;

  // A frame is in progress in every state except the two resting states.
  function automatic logic in_frame(state_t s);
    return (s != S_IDLE) && (s != S_RUN);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream into the loader: valid/ready handshake, byte consumed when
// rx_valid & rx_ready. master = byte source, slave = loader.
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader_timeout.sv
// Inter-byte idle timer. Counts enabled cycles since the last restart and
// pulses expire on the TIMEOUT_CYC-th idle cycle. TIMEOUT_CYC = 0 disables it.
module program_loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, clr_n, restart, enable};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] cnt_reg;

      assign expire = enable & ~restart & (cnt_reg == LAST);

      // Idle-cycle counter; cleared by any handshake, outside a frame, or on expiry.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
          cnt_reg <= '0;
        else if (restart || expire)
          cnt_reg <= '0;
        else if (enable)
          cnt_reg <= cnt_reg + CW'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader for Datapath_Module. Parses framed bytes, builds
// 16-bit words MSB first and writes them to the instruction or data memory
// while holding the core halted; RUN/HALT commands hand the core back and forth.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              clr_n,
  program_loader_if.slave   rx,
  output logic              flag_HLT,
  output logic              test_normal,
  output logic              ext_instr_we,
  output logic [ADDR_W-1:0] ext_instr_addr,
  output logic [DATA_W-1:0] ext_instr_data,
  output logic              ext_data_write_en,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic [DATA_W-1:0] ext_data_data,
  output logic              busy,
  output logic              err_csum,
  output logic              err_timeout
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_IDLE;
`endif

  state_t            state_reg;
  target_t           target_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       cnt_reg;
  logic [7:0]        addr_hi_reg;
  logic [7:0]        cnt_hi_reg;
  logic [7:0]        word_hi_reg;
  logic              rx_ready_reg;
  logic              flag_hlt_reg;
  logic              test_normal_reg;
  logic              instr_we_reg;
  logic [ADDR_W-1:0] instr_addr_reg;
  logic [DATA_W-1:0] instr_data_reg;
  logic              data_we_reg;
  logic [ADDR_W-1:0] data_addr_reg;
  logic [DATA_W-1:0] data_data_reg;
  logic              err_timeout_reg;

  logic              hs;
  logic              expire;
  logic [15:0]       cnt_next;
  logic [DATA_W-1:0] word_next;

  assign hs        = rx.rx_valid & rx_ready_reg;
  assign cnt_next  = {cnt_hi_reg, rx.rx_data};
  assign word_next = DATA_W'({word_hi_reg, rx.rx_data});
  assign busy      = in_frame(state_reg);

  program_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .clr_n  (clr_n),
    .restart(hs | ~busy),
    .enable (busy),
    .expire (expire)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       err_csum_reg;

  // Running XOR of every frame byte after the header, up to the last data byte.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      csum_reg <= '0;
    else if (hs && state_reg == S_IDLE)
      csum_reg <= '0;
    else if (hs && busy && state_reg != S_CSUM)
      csum_reg <= csum_reg ^ rx.rx_data;
  end

  assign err_csum = err_csum_reg;
`else
  assign err_csum = 1'b0;
`endif

  // Frame FSM with registered outputs: parsing, word assembly, address/count, strobes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg       <= S_IDLE;
      target_reg      <= TGT_INSTR;
      addr_reg        <= '0;
      cnt_reg         <= '0;
      addr_hi_reg     <= '0;
      cnt_hi_reg      <= '0;
      word_hi_reg     <= '0;
      rx_ready_reg    <= 1'b1;
      flag_hlt_reg    <= 1'b1;
      test_normal_reg <= 1'b1;
      instr_we_reg    <= 1'b0;
      instr_addr_reg  <= '0;
      instr_data_reg  <= '0;
      data_we_reg     <= 1'b0;
      data_addr_reg   <= '0;
      data_data_reg   <= '0;
      err_timeout_reg <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_csum_reg    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; only the DATA_L handshake raises one.
      instr_we_reg <= 1'b0;
      data_we_reg  <= 1'b0;

      if (expire) begin
        // Abandon the frame; words already written stay in memory.
        err_timeout_reg <= 1'b1;
        rx_ready_reg    <= 1'b1;
        state_reg       <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (hs) begin
              if (rx.rx_data == HDR_INSTR || rx.rx_data == HDR_DATA) begin
                target_reg      <= (rx.rx_data == HDR_INSTR) ? TGT_INSTR : TGT_DATA;
                err_timeout_reg <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                err_csum_reg    <= 1'b0;
`endif
                state_reg       <= S_ADDR_H;
              end else if (rx.rx_data == CMD_RUN) begin
                flag_hlt_reg    <= 1'b0;
                test_normal_reg <= 1'b0;
                state_reg       <= S_RUN;
              end
            end
          end
          S_RUN: begin
            // Everything but HALT is consumed and dropped while the core runs.
            if (hs && rx.rx_data == CMD_HALT) begin
              flag_hlt_reg    <= 1'b1;
              test_normal_reg <= 1'b1;
              state_reg       <= S_IDLE;
            end
          end
          S_ADDR_H: if (hs) begin
            addr_hi_reg <= rx.rx_data;
            state_reg   <= S_ADDR_L;
          end
          S_ADDR_L: if (hs) begin
            addr_reg  <= ADDR_W'({addr_hi_reg, rx.rx_data});
            state_reg <= S_CNT_H;
          end
          S_CNT_H: if (hs) begin
            cnt_hi_reg <= rx.rx_data;
            state_reg  <= S_CNT_L;
          end
          S_CNT_L: if (hs) begin
            cnt_reg   <= cnt_next;
            state_reg <= (cnt_next == 16'd0) ? S_END : S_DATA_H;
          end
          S_DATA_H: if (hs) begin
            word_hi_reg <= rx.rx_data;
            state_reg   <= S_DATA_L;
          end
          S_DATA_L: if (hs) begin
            if (target_reg == TGT_INSTR) begin
              instr_we_reg   <= 1'b1;
              instr_addr_reg <= addr_reg;
              instr_data_reg <= word_next;
            end else begin
              data_we_reg    <= 1'b1;
              data_addr_reg  <= addr_reg;
              data_data_reg  <= word_next;
            end
            rx_ready_reg <= 1'b0;
            state_reg    <= S_WRITE;
          end
          S_WRITE: begin
            // Strobe cycle: advance address (natural wrap) and remaining count.
            rx_ready_reg <= 1'b1;
            addr_reg     <= addr_reg + ADDR_W'(1);
            cnt_reg      <= cnt_reg - 16'd1;
            state_reg    <= (cnt_reg == 16'd1) ? S_END : S_DATA_H;
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: if (hs) begin
            err_csum_reg <= (rx.rx_data != csum_reg);
            state_reg    <= S_IDLE;
          end
`endif
          default: begin
            rx_ready_reg <= 1'b1;
            state_reg    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx.rx_ready       = rx_ready_reg;
  assign flag_HLT          = flag_hlt_reg;
  assign test_normal       = test_normal_reg;
  assign ext_instr_we      = instr_we_reg;
  assign ext_instr_addr    = instr_addr_reg;
  assign ext_instr_data    = instr_data_reg;
  assign ext_data_write_en = data_we_reg;
  assign ext_data_addr     = data_addr_reg;
  assign ext_data_data     = data_data_reg;
  assign err_timeout       = err_timeout_reg;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed frames plus randomized frames checked
// against a frame-level model (expected write list computed from header, start
// address, count and words).
module tb_program_loader;

  localparam int TO = 50;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        flag_HLT, test_normal;
  logic        ext_instr_we, ext_data_write_en;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
  logic        busy, err_csum, err_timeout;

  program_loader_if rx_if ();

  program_loader #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(TO)
  ) dut (
    .clk              (clk),
    .clr_n            (clr_n),
    .rx               (rx_if),
    .flag_HLT         (flag_HLT),
    .test_normal      (test_normal),
    .ext_instr_we     (ext_instr_we),
    .ext_instr_addr   (ext_instr_addr),
    .ext_instr_data   (ext_instr_data),
    .ext_data_write_en(ext_data_write_en),
    .ext_data_addr    (ext_data_addr),
    .ext_data_data    (ext_data_data),
    .busy             (busy),
    .err_csum         (err_csum),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        instr;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [15:0] wq[$];
  int          obs_rd = 0;
  int          checks = 0;
  int          errors = 0;

  // Every strobe cycle seen on either memory port becomes one observed write.
  always @(negedge clk) begin
    if (ext_instr_we)      obs_q.push_back({1'b1, ext_instr_addr, ext_instr_data});
    if (ext_data_write_en) obs_q.push_back({1'b0, ext_data_addr, ext_data_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!rx_if.rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rx_ready_wait", 64'(guard < 20), 64'd1);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  // Sends a whole load frame from wq and records the writes it must cause.
  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] addr,
                            input bit bad_csum, input int gap_max);
    logic [7:0] body[$];
    logic [7:0] cs = 8'h00;
    logic [15:0] n = 16'(wq.size());
    body = '{addr[15:8], addr[7:0], n[15:8], n[7:0]};
    foreach (wq[i]) begin
      body.push_back(wq[i][15:8]);
      body.push_back(wq[i][7:0]);
      exp_q.push_back({hdr == 8'hA5, 16'(addr + 16'(i)), wq[i]});
    end
    foreach (body[i]) cs ^= body[i];
    $display("frame hdr=%02h addr=%04h n=%0d bad_csum=%0d", hdr, addr, n, bad_csum);
    send_byte(hdr, $urandom_range(gap_max));
    foreach (body[i]) send_byte(body[i], $urandom_range(gap_max));
    if (CSUM_EN) send_byte(bad_csum ? ~cs : cs, $urandom_range(gap_max));
  endtask

  // Compares writes seen since the last call against the expected list.
  task automatic check_writes(input string tag);
    int nobs;
    repeat (3) @(negedge clk);
    nobs = obs_q.size() - obs_rd;
    chk($sformatf("%s_nwrites", tag), 64'(nobs), 64'(exp_q.size()));
    for (int i = 0; i < nobs && i < exp_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
    obs_rd += nobs;
    exp_q.delete();
    wq.delete();
    chk($sformatf("%s_busy", tag), 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flag_HLT"}, 64'(flag_HLT), 64'd1);
    chk({tag, "_test_normal"}, 64'(test_normal), 64'd1);
    chk({tag, "_rx_ready"}, 64'(rx_if.rx_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_strobes"}, 64'({ext_instr_we, ext_data_write_en}), 64'd0);
    chk({tag, "_addrs"}, 64'({ext_instr_addr, ext_data_addr}), 64'd0);
    chk({tag, "_datas"}, 64'({ext_instr_data, ext_data_data}), 64'd0);
    chk({tag, "_errs"}, 64'({err_csum, err_timeout}), 64'd0);
  endtask

  initial begin
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;

    // Power-on reset values
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    clr_n = 1'b1;

    // Two-word instruction load
    wq = '{16'h1234, 16'hABCD};
    send_frame(8'hA5, 16'h0010, 1'b0, 0);
    check_writes("instr2");
    chk("instr2_err_csum", 64'(err_csum), 64'd0);

    // Reset while waiting for ADDR_L, then a clean load
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    clr_n = 1'b1;
    check_writes("midreset");
    wq = '{16'h5EED};
    send_frame(8'hA5, 16'h0100, 1'b0, 1);
    check_writes("after_reset");

    // Data load wrapping 0xFFFF -> 0x0000 with a corrupted checksum
    wq = '{16'h0001, 16'h0002};
    send_frame(8'h5A, 16'hFFFF, 1'b1, 0);
    check_writes("wrap");
    chk("wrap_err_csum", 64'(err_csum), 64'(CSUM_EN));

    // Empty frame: no strobes, error flags cleared by the header
    send_frame(8'hA5, 16'h0000, 1'b0, 0);
    check_writes("empty");
    chk("empty_err_csum", 64'(err_csum), 64'd0);

    // RUN, ignored bytes, HALT
    send_byte(8'hC3, 0);
    chk("run_flags", 64'({flag_HLT, test_normal}), 64'd0);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    chk("run_ignore_flags", 64'({flag_HLT, test_normal}), 64'd0);
    send_byte(8'h3C, 0);
    chk("halt_flags", 64'({flag_HLT, test_normal}), 64'h3);
    check_writes("run");

    // Inter-byte timeout
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    repeat (TO - 10) @(posedge clk);
    #1;
    chk("timeout_pending", 64'({busy, err_timeout}), 64'h2);
    repeat (15) @(posedge clk);
    #1;
    chk("timeout_fired", 64'({busy, err_timeout}), 64'h1);
    check_writes("timeout");

    // Randomized frames against the frame-level model
    for (int f = 0; f < 10; f++) begin
      logic [15:0] a;
      logic [7:0]  h;
      bit          bad;
      h   = ($urandom_range(1) != 0) ? 8'hA5 : 8'h5A;
      a   = ($urandom_range(3) == 0) ? 16'(16'hFFFD + 16'($urandom_range(2)))
                                     : 16'($urandom);
      bad = ($urandom_range(1) != 0);
      for (int w = 0; w < int'($urandom_range(5)); w++) wq.push_back(16'($urandom));
      send_frame(h, a, bad, 3);
      check_writes($sformatf("rand%0d", f));
      chk($sformatf("rand%0d_errs", f), 64'({err_csum, err_timeout}),
          64'({CSUM_EN & bad, 1'b0}));
      chk($sformatf("rand%0d_flags", f), 64'({flag_HLT, test_normal}), 64'h3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
